// File: rtl/adpcm_pkg.sv
// rtl/adpcm_pkg.sv - IMA ADPCM tables, FSM encoding and arithmetic helpers
package adpcm_pkg;

    localparam int IDX_MAX = 88;

    localparam logic [14:0] STEP_TAB [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    localparam logic signed [4:0] IDX_TAB [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_STEP, ST_B2, ST_B1, ST_B0, ST_UPD, ST_DONE
    } adpcm_st_t;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic [6:0] clamp_idx(input logic [6:0] idx, input logic signed [4:0] delta);
        logic signed [8:0] s;
        s = $signed({2'b00, idx}) + 9'(delta);
        if (s < 9'sd0)
            return 7'd0;
        else if (s > 9'(IDX_MAX))
            return 7'(IDX_MAX);
        else
            return s[6:0];
    endfunction

endpackage

// File: rtl/adpcm_step_rom.sv
// rtl/adpcm_step_rom.sv - registered step-size lookup indexed by step index
module adpcm_step_rom
    import adpcm_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [6:0]  addr,
    output logic [14:0] step
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            step <= '0;
        else if (addr <= 7'(IDX_MAX))
            step <= STEP_TAB[addr];
        else
            step <= STEP_TAB[IDX_MAX];
    end

endmodule

// File: rtl/adpcm_mc.sv
// rtl/adpcm_mc.sv - multi-channel IMA ADPCM encoder/decoder with toggle request handshake
module adpcm_mc
    import adpcm_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 req,
    input  logic                 sel_rx,
    input  logic [CW-1:0]        ch_sel,
    input  logic signed [15:0]   rx_pcm,
    input  logic [3:0]           rx_adpcm,
    output logic                 ack,
    output logic [3:0]           tx_adpcm,
    output logic signed [15:0]   tx_pcm,
    output logic [CW-1:0]        tx_ch,
    output logic                 err
);

    adpcm_st_t st, nxt;

    logic                req_q, mode_q, sgn_q, bad_q;
    logic [CW-1:0]       ch_q;
    logic signed [15:0]  pcm_q;
    logic [3:0]          code_q;
    logic [14:0]         step_q, rom_step;
    logic [16:0]         d_q, vp_q;

    logic signed [15:0]  pred_arr [CH];
    logic [6:0]          idx_arr  [CH];

    logic                capture, do_upd, do_done, take;
    logic [CW-1:0]       rom_ch, cur_ch;
    logic signed [15:0]  pred_cur;
    logic [6:0]          idx_cur;
    logic signed [16:0]  diff;
    logic signed [17:0]  sum;
    logic [16:0]         w;
    logic [2:0]          bmask;

    function automatic logic in_range(input logic [CW-1:0] c);
        return int'(c) < CH;
    endfunction

    // The ROM is addressed from the live channel select so its output is ready in STEP.
    assign rom_ch   = in_range(ch_sel) ? ch_sel : '0;
    assign cur_ch   = bad_q ? '0 : ch_q;
    assign pred_cur = pred_arr[cur_ch];
    assign idx_cur  = idx_arr[cur_ch];
    assign diff     = {pcm_q[15], pcm_q} - {pred_cur[15], pred_cur};
    assign sum      = sgn_q ? $signed({{2{pred_cur[15]}}, pred_cur} - {1'b0, vp_q})
                            : $signed({{2{pred_cur[15]}}, pred_cur} + {1'b0, vp_q});

    adpcm_step_rom u_step_rom (
        .clk  (clk),
        .rstn (rstn),
        .addr (idx_arr[rom_ch]),
        .step (rom_step)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            st <= ST_IDLE;
        else
            st <= nxt;
    end

    always_comb begin
        nxt = st;
        if (!enable) begin
            nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: if (req != req_q) nxt = ST_STEP;
                ST_STEP: nxt = ST_B2;
                ST_B2:   nxt = ST_B1;
                ST_B1:   nxt = ST_B0;
                ST_B0:   nxt = ST_UPD;
                ST_UPD:  nxt = ST_DONE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        capture = enable && (st == ST_IDLE) && (req != req_q);
        do_upd  = enable && (st == ST_UPD);
        do_done = enable && (st == ST_DONE);
        w       = '0;
        bmask   = '0;
        case (st)
            ST_B2: begin w = {2'b00, step_q};         bmask = 3'b100; end
            ST_B1: begin w = {3'b000, step_q[14:1]};  bmask = 3'b010; end
            ST_B0: begin w = {4'b0000, step_q[14:2]}; bmask = 3'b001; end
            default: ;
        endcase
        take = mode_q ? |(code_q[2:0] & bmask) : (d_q >= w);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q    <= 1'b0;
            mode_q   <= 1'b0;
            sgn_q    <= 1'b0;
            bad_q    <= 1'b0;
            ch_q     <= '0;
            pcm_q    <= '0;
            code_q   <= '0;
            step_q   <= '0;
            d_q      <= '0;
            vp_q     <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            tx_adpcm <= '0;
            tx_pcm   <= '0;
            tx_ch    <= '0;
        end else if (!enable) begin
            req_q <= req;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= do_done;
            err <= do_done && bad_q;
            if (capture) begin
                req_q  <= req;
                mode_q <= sel_rx;
                ch_q   <= ch_sel;
                bad_q  <= !in_range(ch_sel);
                pcm_q  <= rx_pcm;
                code_q <= rx_adpcm;
            end
            case (st)
                ST_STEP: begin
                    step_q <= rom_step;
                    vp_q   <= {5'b0, rom_step[14:3]};
                    if (mode_q) begin
                        sgn_q <= code_q[3];
                    end else begin
                        sgn_q  <= diff[16];
                        d_q    <= diff[16] ? -diff : diff;
                        code_q <= {diff[16], 3'b000};
                    end
                end
                ST_B2, ST_B1, ST_B0: begin
                    if (take) begin
                        vp_q <= vp_q + w;
                        if (!mode_q) begin
                            d_q    <= d_q - w;
                            code_q <= code_q | {1'b0, bmask};
                        end
                    end
                end
                ST_UPD: begin
                    tx_ch <= ch_q;
                    if (bad_q) begin
                        tx_pcm   <= '0;
                        tx_adpcm <= '0;
                    end else begin
                        tx_pcm   <= sat16(sum);
                        tx_adpcm <= mode_q ? 4'h0 : code_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flop arrays rather than RAM so that disabling clears every channel in one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CH; i++) begin
                pred_arr[i] <= '0;
                idx_arr[i]  <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < CH; i++) begin
                pred_arr[i] <= '0;
                idx_arr[i]  <= '0;
            end
        end else if (do_upd && !bad_q) begin
            pred_arr[cur_ch] <= sat16(sum);
            idx_arr[cur_ch]  <= clamp_idx(idx_cur, IDX_TAB[code_q[2:0]]);
        end
    end

endmodule
